pipelined_adder_nbit: RTL
=========================

# pipelined_adder_nbit

Parametrised, pipelined successor to the fixed 64-bit two-chunk adder. It splits a WIDTH-bit add or subtract into STAGES = WIDTH/CHUNK carry-propagating chunks and registers the inter-chunk carry. This gives one operation per cycle at CHUNK-bit critical path. A valid/ready handshake sits on both sides, and signed overflow is flagged. It sits between operand registers and the ALU result mux of the datapath.

## Interface
- WIDTH, 64: operand and sum width; must be a multiple of CHUNK.
- CHUNK, 32: bits added per pipeline stage; STAGES = WIDTH/CHUNK, minimum 1.
- clk  in  1  clock; all state updates on its rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- in_valid  in  1  operands present.
- in_ready  out  1  block accepts operands this cycle.
- a, b  in  WIDTH  operands.
- cin  in  1  carry-in; ignored when sub=1.
- sub  in  1  0 = a+b+cin; 1 = a-b (a + ~b + 1).
- out_valid  out  1  result present.
- out_ready  in  1  consumer accepts result.
- sum  out  WIDTH  result.
- cout  out  1  carry out of bit WIDTH-1. For sub it is the inverted-borrow convention: 1 means no borrow.
- ovf  out  1  signed overflow: carry into MSB XOR carry out of MSB.

## Operation
- Transfer on the input side when in_valid & in_ready. Transfer on the output side when out_valid & out_ready.
- Global advance enable: adv = !out_valid | out_ready. in_ready = adv (combinational).
- When adv=1, every stage register loads from its predecessor. The valid bit for each stage travels with its data. When adv=0, all registers hold.
- Stage k (0..STAGES-1) adds chunk k of a and b' (b' = sub ? ~b : b) plus carry_k.
  - carry_0 = sub ? 1 : cin.
  - carry_{k+1} is registered along with the partial sum.
- Operands for chunks above k are delayed k cycles (skew registers), so each chunk meets its own carry.
- Partial sums for chunks below k are carried forward (deskew) so the full sum emerges aligned.
- The final stage registers sum, cout and ovf. ovf is computed from the carry into bit WIDTH-1 and the carry out of bit WIDTH-1.
- Bubbles (invalid slots) are not collapsed; they advance like data.
- Data registers are not reset; only valid bits are.
- Elaboration fails (generate-time error) if WIDTH % CHUNK != 0 or CHUNK > WIDTH.

## Timing
- Latency: STAGES cycles from accepting an input to out_valid=1, provided there is no backpressure. Default config: 2.
- Throughput: 1 op/cycle while out_ready=1.
- Reset: while rst_n=0 at a clock edge, all stage valid bits clear.
  - After reset: out_valid=0, in_ready=1.
  - sum, cout and ovf are 0 after reset: output registers are reset, internal data registers are not.
- Reset mid-operation: all in-flight ops are discarded, with no partial output. An input presented in the reset cycle is not accepted.
- Backpressure: out_valid=1 & out_ready=0 freezes the whole pipeline and deasserts in_ready in the same cycle. sum, cout and ovf stay stable while out_valid=1 and out_ready=0.
- Simultaneous output accept and input accept in one cycle is legal; the pipeline shifts by one.
- out_valid=0 forces adv=1, so empty slots never block input.

## Structure
- Shared package/header adder_pkg: op encoding constants OP_ADD=1'b0 and OP_SUB=1'b1, and the STAGES derivation macro/function.
- Sub-module adder_chunk: combinational CHUNK-bit add with cin, producing sum, cout and carry-into-MSB. Instantiated STAGES times via generate.
- Top level holds the skew/deskew shift registers, the valid chain and the handshake logic.
- The existing full_adder_32_bit may serve as adder_chunk's body when CHUNK=32, but the chunk must also expose carry-into-MSB.

## Test plan
- Reset then idle, default params: rst_n low 2 cycles, then high -> out_valid=0, in_ready=1, sum=0, cout=0, ovf=0.
- Add with carry across the chunk boundary: a=64'h0000_0000_FFFF_FFFF, b=1, cin=0, sub=0 -> 2 cycles later sum=64'h0000_0001_0000_0000, cout=0, ovf=0.
- Overflow, back-to-back ops:
  - Cycle n: a=64'h7FFF_FFFF_FFFF_FFFF, b=1 -> sum=64'h8000_0000_0000_0000, ovf=1, cout=0.
  - Cycle n+1: a=64'hFFFF_FFFF_FFFF_FFFF, b=1, cin=1 -> sum=1, cout=1, ovf=0.
  - Results appear on consecutive cycles.
- Subtract: a=5, b=7, sub=1, cin=1 (ignored) -> sum=64'hFFFF_FFFF_FFFF_FFFE, cout=0 (borrow), ovf=0.
  - a=7, b=5, sub=1 -> sum=2, cout=1.
- Backpressure: stream 4 ops with out_ready=0 from cycle 3 for 3 cycles.
  - in_ready drops in the same cycle out_valid=1 & out_ready=0.
  - sum is held stable throughout.
  - All 4 results are delivered in order, none duplicated or lost.
- Parametrisation and mid-flight reset: WIDTH=32, CHUNK=8 (STAGES=4), random ops vs reference model -> latency 4, all match. Reset asserted with 3 ops in flight -> no out_valid afterwards until new input.

Source files
------------

// File: rtl/adder_pkg.sv
// Shared definitions for the chunked pipelined adder: op encoding and stage count.
package adder_pkg;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  // Number of carry-propagating chunks; degenerate configs collapse to one stage.
  function automatic int unsigned num_stages(input int unsigned width, input int unsigned chunk);
    if (chunk == 0 || chunk > width) return 1;
    return width / chunk;
  endfunction

endpackage

// File: rtl/adder_chunk.sv
// Combinational CHUNK-bit adder slice exposing carry-out and carry-into-MSB.
module adder_chunk #(
  parameter int unsigned CHUNK = 32
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             cin,
  output logic [CHUNK-1:0] sum_c,
  output logic             cout_c,
  output logic             cmsb_c
);

  logic [CHUNK:0] full;

  assign full   = {1'b0, a} + {1'b0, b} + (CHUNK+1)'(cin);
  assign sum_c  = full[CHUNK-1:0];
  assign cout_c = full[CHUNK];
  // The MSB sum bit is a^b^carry_in, so the carry into it falls out directly.
  assign cmsb_c = a[CHUNK-1] ^ b[CHUNK-1] ^ full[CHUNK-1];

endmodule

// File: rtl/pipelined_adder_nbit.sv
// WIDTH-bit add/subtract split into CHUNK-bit stages with registered inter-chunk carry,
// operand skew and sum deskew, and a valid/ready handshake on both sides.
module pipelined_adder_nbit
  import adder_pkg::*;
#(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned CHUNK = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int unsigned STAGES = num_stages(WIDTH, CHUNK);
  localparam int unsigned NREG   = (STAGES > 1) ? STAGES - 1 : 1;
  localparam logic [WIDTH-1:0] CMASK = WIDTH'({CHUNK{1'b1}});

  if (CHUNK == 0 || CHUNK > WIDTH || (WIDTH % CHUNK) != 0) begin : g_bad_cfg
    $error("pipelined_adder_nbit: WIDTH must be a non-zero multiple of CHUNK");
  end

  logic             adv;
  logic [WIDTH-1:0] b_eff;
  logic             carry0;

  // Stage k inputs (from the port for k=0, else from register k-1) and results.
  logic [WIDTH-1:0] xin   [STAGES];
  logic [WIDTH-1:0] yin   [STAGES];
  logic             cin_s [STAGES];
  logic             vin   [STAGES];
  logic [CHUNK-1:0] csum  [STAGES];
  logic             cout_s[STAGES];
  logic             cmsb_s[STAGES];
  logic [WIDTH-1:0] xout  [STAGES];

  // Inter-stage registers: x holds finished low chunks plus raw high chunks of a.
  logic [WIDTH-1:0] x_q [NREG];
  logic [WIDTH-1:0] y_q [NREG];
  logic             c_q [NREG];
  logic             v_q [NREG];

  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;
  assign b_eff    = (sub == OP_SUB) ? ~b : b;
  assign carry0   = (sub == OP_SUB) ? 1'b1 : cin;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int unsigned LSB = k * CHUNK;

    if (k == 0) begin : g_src
      assign xin[k]   = a;
      assign yin[k]   = b_eff;
      assign cin_s[k] = carry0;
      assign vin[k]   = in_valid;
    end else begin : g_link
      assign xin[k]   = x_q[k-1];
      assign yin[k]   = y_q[k-1];
      assign cin_s[k] = c_q[k-1];
      assign vin[k]   = v_q[k-1];
    end

    adder_chunk #(.CHUNK(CHUNK)) u_chunk (
      .a      (xin[k][LSB +: CHUNK]),
      .b      (yin[k][LSB +: CHUNK]),
      .cin    (cin_s[k]),
      .sum_c  (csum[k]),
      .cout_c (cout_s[k]),
      .cmsb_c (cmsb_s[k])
    );

    assign xout[k] = (xin[k] & ~(CMASK << LSB)) | (WIDTH'(csum[k]) << LSB);

    if (k < STAGES - 1) begin : g_reg
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          v_q[k] <= 1'b0;
        end else if (adv) begin
          v_q[k] <= vin[k];
        end
      end

      // Data path is not reset; the valid bit alone qualifies it.
      always_ff @(posedge clk) begin
        if (adv) begin
          x_q[k] <= xout[k];
          y_q[k] <= yin[k];
          c_q[k] <= cout_s[k];
        end
      end
    end
  end

  // Final stage; result fields only update on a valid slot so they stay clean after reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      sum       <= '0;
      cout      <= 1'b0;
      ovf       <= 1'b0;
    end else if (adv) begin
      out_valid <= vin[STAGES-1];
      if (vin[STAGES-1]) begin
        sum  <= xout[STAGES-1];
        cout <= cout_s[STAGES-1];
        ovf  <= cout_s[STAGES-1] ^ cmsb_s[STAGES-1];
      end
    end
  end

endmodule
